// File: rtl/conv_encoder.sv
// rtl/conv_encoder.sv - rate-1/2, K=3 convolutional encoder with zero-tail frame termination
//
// Accepts FRAME_LEN information bits per frame over a valid/ready handshake. It then
// encodes two zero tail bits so that every frame ends in trellis state 0. Each 2-bit
// code symbol leaves through a registered valid/ready output stage.
//
// Ports:
//   clk        - clock; all state updates on the rising edge
//   rst        - asynchronous active-high reset
//   start      - one-cycle frame request, sampled only in IDLE
//   in_valid   - in_bit is valid
//   in_bit     - information bit
//   in_ready   - encoder accepts in_bit this cycle (combinational from out_ready)
//   out_valid  - out_sym holds a valid code symbol
//   out_sym    - {G0 parity, G1 parity}
//   out_last   - final tail symbol of the frame, qualified by out_valid
//   out_ready  - downstream accepts the symbol
//   enc_state  - shift register contents {b(n-1), b(n-2)}
//   busy       - FSM not IDLE or a symbol still pending
module conv_encoder #(
   parameter int         FRAME_LEN = 8,
   parameter logic [2:0] G0        = 3'b111,
   parameter logic [2:0] G1        = 3'b101
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       in_valid,
   input  logic       in_bit,
   output logic       in_ready,
   output logic       out_valid,
   output logic [1:0] out_sym,
   output logic       out_last,
   input  logic       out_ready,
   output logic [1:0] enc_state,
   output logic       busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_TAIL = 2'd2
   } state_t;

   localparam logic [7:0] LAST_IDX = 8'(FRAME_LEN - 1);

   state_t     state_q, state_d;
   logic [1:0] sr_q, sr_d;
   logic [7:0] cnt_q, cnt_d;
   logic       tail_q, tail_d;          // 0: first tail bit next, 1: second (final) tail bit next
   logic       out_valid_q, out_valid_d;
   logic [1:0] out_sym_q, out_sym_d;
   logic       out_last_q, out_last_d;

   logic       slot_free;
   logic       load;
   logic       enc_bit;
   logic       last_sym;
   logic [2:0] w;

   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      cnt_d       = cnt_q;
      tail_d      = tail_q;
      out_valid_d = out_valid_q;
      out_sym_d   = out_sym_q;
      out_last_d  = out_last_q;
      in_ready    = 1'b0;
      load        = 1'b0;
      enc_bit     = 1'b0;
      last_sym    = 1'b0;

      // The output register can take a new symbol when it is empty or being drained now.
      slot_free = !out_valid_q || out_ready;

      // A drained symbol clears valid unless a new one is loaded below.
      if (out_ready) begin
         out_valid_d = 1'b0;
      end

      unique case (state_q)
         S_IDLE: begin
            // The pending last symbol of the previous frame lives in the output register,
            // so clearing sr here cannot disturb it.
            if (start) begin
               state_d = S_DATA;
               sr_d    = 2'b00;
               cnt_d   = 8'd0;
               tail_d  = 1'b0;
            end
         end
         S_DATA: begin
            in_ready = slot_free;
            if (in_valid && slot_free) begin
               load    = 1'b1;
               enc_bit = in_bit;
               cnt_d   = cnt_q + 8'd1;
               if (cnt_q == LAST_IDX) begin
                  state_d = S_TAIL;
                  tail_d  = 1'b0;
               end
            end
         end
         S_TAIL: begin
            if (slot_free) begin
               load = 1'b1;
               if (tail_q) begin
                  last_sym = 1'b1;
                  state_d  = S_IDLE;
               end else begin
                  tail_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      w = {enc_bit, sr_q};
      if (load) begin
         out_valid_d = 1'b1;
         out_sym_d   = {^(w & G0), ^(w & G1)};
         out_last_d  = last_sym;
         sr_d        = {enc_bit, sr_q[1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         sr_q        <= 2'b00;
         cnt_q       <= 8'd0;
         tail_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_sym_q   <= 2'b00;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
         tail_q      <= tail_d;
         out_valid_q <= out_valid_d;
         out_sym_q   <= out_sym_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sym   = out_sym_q;
   assign out_last  = out_last_q;
   assign enc_state = sr_q;
   assign busy      = (state_q != S_IDLE) || out_valid_q;

endmodule

// File: tb/tb_conv_encoder.sv
// tb/tb_conv_encoder.sv - self-checking bench for conv_encoder
module tb_conv_encoder;

   localparam int         FL  = 4;
   localparam logic [2:0] TG0 = 3'b111;
   localparam logic [2:0] TG1 = 3'b101;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       in_valid;
   logic       in_bit;
   logic       in_ready;
   logic       out_valid;
   logic [1:0] out_sym;
   logic       out_last;
   logic       out_ready;
   logic [1:0] enc_state;
   logic       busy;

   int tests = 0;
   int fails = 0;
   logic [11:0] frame_log;

   conv_encoder #(.FRAME_LEN(FL), .G0(TG0), .G1(TG1)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_sym   (out_sym),
      .out_last  (out_last),
      .out_ready (out_ready),
      .enc_state (enc_state),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Symbol s of a frame is the convolution of the zero-padded bit sequence with G0/G1.
   function automatic logic [1:0] model_sym(input logic [3:0] bits, input int s);
      logic [2:0] w;
      logic [2:0] g0;
      logic [2:0] g1;
      g0 = TG0;
      g1 = TG1;
      for (int k = 0; k < 3; k++) begin
         int p;
         p = s - k;
         w[2-k] = (p >= 0 && p < FL) ? bits[p] : 1'b0;
      end
      return {^(w & g0), ^(w & g1)};
   endfunction

   // Drives one frame (bits[0] first) and checks every symbol handshake against the model.
   // Entered and left at posedge+1.
   task automatic run_frame(input logic [3:0] bits, input int stall_from, input int stall_len,
                            input bit pulse, input bit chain, input bit skip_start,
                            input int abort_at);
      int idx = 0;
      int s   = 0;
      int cyc = 0;
      bit done = 0;
      frame_log = '0;
      if (skip_start) begin
         start = 1'b0;
      end else begin
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
      while (!done) begin
         if (cyc > 60) begin
            chk("frame_timeout", 16'(cyc), 16'(FL + 2));
            return;
         end
         if (abort_at > 0 && idx == abort_at) begin
            in_valid  = 1'b0;
            out_ready = 1'b1;
            rst       = 1'b1;
            #1;
            chk("abort_out_valid", 16'(out_valid), 16'd0);
            chk("abort_out_last", 16'(out_last), 16'd0);
            chk("abort_enc_state", 16'(enc_state), 16'd0);
            chk("abort_busy", 16'(busy), 16'd0);
            chk("abort_in_ready", 16'(in_ready), 16'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            return;
         end
         in_valid  = (idx < FL);
         in_bit    = (idx < FL) ? bits[idx] : 1'b0;
         out_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
         start     = (pulse && (cyc == 2 || cyc == FL)) || (chain && cyc == FL + 2);
         @(negedge clk);
         if (out_valid && out_ready) begin
            chk("sym", 16'(out_sym), 16'(model_sym(bits, s)));
            chk("last", 16'(out_last), 16'(s == FL + 1));
            frame_log = {frame_log[9:0], out_sym};
            s++;
            if (s == FL + 2) begin
               done = 1;
               chk("frame_cycles", 16'(cyc), 16'(FL + 2 + stall_len));
            end
         end else if (out_valid && !out_ready) begin
            chk("stall_sym_hold", 16'(out_sym), 16'(model_sym(bits, s)));
            chk("stall_last_hold", 16'(out_last), 16'(s == FL + 1));
            chk("stall_in_ready", 16'(in_ready), 16'd0);
         end
         if (in_valid && in_ready) idx++;
         @(posedge clk); #1;
         cyc++;
      end
      start     = chain;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("end_enc_state", 16'(enc_state), 16'd0);
      if (!chain) begin
         start = 1'b0;
         chk("end_busy", 16'(busy), 16'd0);
         chk("end_out_valid", 16'(out_valid), 16'd0);
      end
   endtask

   initial begin
      logic [3:0] rb;
      rst       = 1'b1;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_bit    = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 16'(out_valid), 16'd0);
      chk("rst_out_sym", 16'(out_sym), 16'd0);
      chk("rst_out_last", 16'(out_last), 16'd0);
      chk("rst_in_ready", 16'(in_ready), 16'd0);
      chk("rst_enc_state", 16'(enc_state), 16'd0);
      chk("rst_busy", 16'(busy), 16'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_in_ready", 16'(in_ready), 16'd0);

      // bits 1,0,1,1 -> 11 10 00 01 01 11
      run_frame(4'b1101, 0, 0, 0, 0, 0, 0);
      chk("seq_1011", 16'(frame_log), 16'b11_10_00_01_01_11);

      run_frame(4'b0000, 0, 0, 0, 0, 0, 0);
      chk("seq_0000", 16'(frame_log), 16'd0);

      // out_ready low for 3 cycles after the first symbol appears
      run_frame(4'b1101, 1, 3, 0, 0, 0, 0);
      chk("seq_stall", 16'(frame_log), 16'b11_10_00_01_01_11);

      // start pulses during DATA and TAIL
      run_frame(4'b1101, 0, 0, 1, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("pulse_no_extra", 16'(out_valid), 16'd0);

      // reset after the second input bit, then a clean frame
      run_frame(4'b1101, 0, 0, 0, 0, 0, 2);
      run_frame(4'b1101, 0, 0, 0, 0, 0, 0);
      chk("seq_after_rst", 16'(frame_log), 16'b11_10_00_01_01_11);

      // back-to-back frames, second started while the first out_last is pending
      run_frame(4'b1101, 0, 0, 0, 1, 0, 0);
      run_frame(4'b0111, 0, 0, 0, 0, 1, 0);

      // randomized frames with random stalls and start pulses
      for (int f = 0; f < 8; f++) begin
         rb = 4'($urandom);
         run_frame(rb, int'($urandom_range(1, FL + 1)), int'($urandom_range(0, 3)),
                   1'($urandom), 0, 0, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/conv_encoder.md
# conv_encoder

Rate-1/2, constraint-length-3 convolutional encoder that produces the 2-bit code symbols consumed by the Viterbi decoder's branch metric unit. It accepts a frame of FRAME_LEN information bits through a valid/ready handshake and appends two zero tail bits so every frame terminates in trellis state 0. Each 2-bit symbol is emitted through a registered valid/ready output. Trellis state numbering matches the decoder: state s0..s3 is the shift-register value.

## Interface
- FRAME_LEN, 8, information bits per frame; legal range 1..255.
- G0, 3'b111, generator for out_sym[1]; bit 2 taps the current bit, bit 0 taps the oldest bit.
- G1, 3'b101, generator for out_sym[0]; same tap ordering as G0.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin a frame; sampled only in IDLE.
- in_valid  in  1  in_bit is valid.
- in_bit  in  1  information bit.
- in_ready  out  1  encoder accepts in_bit this cycle.
- out_valid  out  1  out_sym holds a valid code symbol.
- out_sym  out  2  code symbol; [1] is the G0 parity, [0] is the G1 parity.
- out_last  out  1  marks the final tail symbol of the frame; qualified by out_valid.
- out_ready  in  1  downstream accepts the symbol.
- enc_state  out  2  current shift-register contents {b(n-1), b(n-2)}.
- busy  out  1  high when FSM is not IDLE or out_valid is high.

## Operation
- Reset values: FSM IDLE, shift register 00, bit counter 0, out_valid 0, out_sym 00, out_last 0, in_ready 0, enc_state 00, busy 0.
- Symbol computation: window w = {b, sr[1], sr[0]}, where b is the bit being encoded.
  - out_sym[1] = ^(w & G0).
  - out_sym[0] = ^(w & G1).
  - Next sr = {b, sr[1]}.
- Slot free: `slot_free = !out_valid || out_ready`.
- IDLE
  - in_ready = 0.
  - start = 1 transitions to DATA, clears sr and the bit counter.
  - start outside IDLE is ignored.
- DATA
  - in_ready = slot_free.
  - When in_valid && in_ready: encode in_bit, load the output register, increment the counter.
  - Accepting bit FRAME_LEN-1 transitions to TAIL.
- TAIL
  - in_ready = 0.
  - Internally encodes b = 0 twice, each time slot_free is high.
  - The second tail symbol is loaded with out_last = 1, and the FSM returns to IDLE in the same edge.
- Output register behaviour:
  - out_valid clears when out_ready is high and no new symbol is loaded.
  - While out_valid && !out_ready, out_sym and out_last hold stable.
  - No symbol is ever dropped or duplicated.
- A frame always yields exactly FRAME_LEN+2 symbols and ends with enc_state = 00.
- Back-to-back frames: start may be accepted in IDLE while the last symbol is still pending. Clearing sr has no effect on the pending symbol.
- Reset mid-frame aborts the frame immediately. The partial frame is discarded, outputs return to reset values, and no out_last is produced.

## Timing
- start sampled at edge k puts the FSM in DATA after edge k, so in_ready can be high in cycle k+1.
- Input accepted at edge n produces out_valid = 1 with the corresponding out_sym after edge n (1-cycle latency).
- Throughput is one symbol per cycle when in_valid and out_ready stay high.
  - Frame time from start to the last symbol: FRAME_LEN+3 cycles.
  - The two TAIL cycles follow DATA without a bubble.
- Backpressure: out_ready low stalls in_ready and TAIL progress in the same cycle (combinational path from out_ready to in_ready).
- enc_state updates on the same edge as the symbol load.

## Test plan
- FRAME_LEN=4, bits 1,0,1,1, out_ready = 1 -> symbols 11, 10, 00, 01, 01, 11; out_last only on the 6th symbol; enc_state returns to 00.
- FRAME_LEN=4, bits 0,0,0,0 -> six symbols of 00; busy drops after the final handshake.
- Bits 1,0,1,1 with out_ready held low 3 cycles after the first symbol -> out_sym holds 11, in_ready = 0 during the stall, and the sequence resumes 10, 00, 01, 01, 11 with nothing lost.
- start pulsed during DATA and TAIL -> ignored; the frame still yields exactly FRAME_LEN+2 symbols.
- rst asserted after the 2nd input bit -> out_valid drops asynchronously, FSM returns to IDLE, enc_state = 00. A new frame 1,0,1,1 then produces the correct 11, 10, 00, 01, 01, 11.
- Two frames back-to-back (start in the cycle after out_last is loaded) -> 12 symbols total with out_last exactly on symbols 6 and 12; the second frame's encoding starts from state 00.
